// File: rtl/conv_link_pkg.sv
// Shared definitions for the conv_link_master host driver.
// Holds the FSM state type, link geometry and response field positions.
package conv_link_pkg;

  localparam int unsigned BYTES      = 4;            // bytes per window / weight set
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned WORD_W     = BYTES * BYTE_W;
  localparam int unsigned RESP_W     = 10;           // {toggle, max[8:0]}
  localparam int unsigned TOGGLE_BIT = 9;
  localparam int unsigned RESULT_W   = RESP_W - 1;

  typedef enum logic [2:0] {
    StIdle,
    StSendW,
    StSendX,
    StSettle,
    StCap0,
    StCap1
  } state_e;

  // Link-level view of a state: does the core see a byte being sent?
  function automatic logic is_send_state(state_e st);
    return (st == StSendW) || (st == StSendX);
  endfunction

endpackage

// File: rtl/conv_link_master_if.sv
// Host and link signals of conv_link_master grouped in one bundle.
//   master modport: the driver (conv_link_master) itself.
//   slave modport : the host/core side that feeds it and reads results.
// Host side : start, load_weights, win_in, wgt_in -> busy, done, result, err
// Link side : link_data, link_wsel, link_rd -> core; link_resp <- core
interface conv_link_master_if;
  import conv_link_pkg::*;

  logic                start;
  logic                load_weights;
  logic [WORD_W-1:0]   win_in;
  logic [WORD_W-1:0]   wgt_in;
  logic                busy;
  logic                done;
  logic [RESULT_W-1:0] result;
  logic                err;
  logic [BYTE_W-1:0]   link_data;
  logic                link_wsel;
  logic                link_rd;
  logic [RESP_W-1:0]   link_resp;

  modport master (
    input  start, load_weights, win_in, wgt_in, link_resp,
    output busy, done, result, err, link_data, link_wsel, link_rd
  );

  modport slave (
    output start, load_weights, win_in, wgt_in, link_resp,
    input  busy, done, result, err, link_data, link_wsel, link_rd
  );

endinterface

// File: rtl/conv_link_serializer.sv
// Byte serializer for the conv link.
// Loads a BYTES-wide word and presents byte k = word[8k+7:8k] on a registered
// output, k = 0 first, advancing one byte per step. last is high while the
// final byte is presented.
// Ports:
//   clk   clock
//   clear synchronous clear: data -> 0, index -> 0 (takes priority)
//   load  capture word, present byte 0 next cycle
//   step  present next byte next cycle
//   word  word to serialize
//   data  registered byte for the link
//   last  current byte is byte BYTES-1
module conv_link_serializer
  import conv_link_pkg::*;
(
  input  logic              clk,
  input  logic              clear,
  input  logic              load,
  input  logic              step,
  input  logic [WORD_W-1:0] word,
  output logic [BYTE_W-1:0] data,
  output logic              last
);

  localparam int unsigned CntW  = $clog2(BYTES);
  localparam int unsigned RestW = WORD_W - BYTE_W;

  logic [BYTE_W-1:0] data_q;
  logic [RestW-1:0]  rest_q;
  logic [CntW-1:0]   cnt_q;

  always_ff @(posedge clk) begin
    if (clear) begin
      data_q <= '0;
      rest_q <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      data_q <= word[BYTE_W-1:0];
      rest_q <= word[WORD_W-1:BYTE_W];
      cnt_q  <= '0;
    end else if (step) begin
      data_q <= rest_q[BYTE_W-1:0];
      rest_q <= {{BYTE_W{1'b0}}, rest_q[RestW-1:BYTE_W]};
      cnt_q  <= cnt_q + CntW'(1);
    end
  end

  assign data = data_q;
  assign last = (cnt_q == CntW'(BYTES - 1));

endmodule

// File: rtl/conv_link_master.sv
// Host-side driver for the 2x2 convolution core's byte-serial link.
// Serializes optional weights then the window, parks the link, waits for the
// core pipeline to settle and captures the {toggle, max} response twice to
// check that the toggle bit is alive.
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   bus.master  host handshake (start/load_weights/win_in/wgt_in ->
//               busy/done/result/err) and link (link_data/link_wsel/link_rd,
//               link_resp)
// All outputs are registered; link_rd idles high so the core never shifts a
// stray byte into its window.
module conv_link_master
  import conv_link_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  conv_link_master_if.master  bus
);

  localparam int unsigned SetW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_e              state_q, state_d;
  logic [SetW-1:0]     set_cnt_q, set_cnt_d;
  logic [WORD_W-1:0]   win_q;
  logic                busy_q, done_q, err_q, wsel_q, rd_q, f0_q;
  logic [RESULT_W-1:0] result_q;

  logic                ser_clear, ser_load, ser_step, ser_last;
  logic [WORD_W-1:0]   ser_word;
  logic [BYTE_W-1:0]   ser_data;
  logic                accept;

  assign accept = (state_q == StIdle) && bus.start;

  always_comb begin
    state_d   = state_q;
    set_cnt_d = set_cnt_q;
    ser_clear = 1'b0;
    ser_load  = 1'b0;
    ser_step  = 1'b0;
    ser_word  = bus.wgt_in;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          ser_load = 1'b1;
          if (bus.load_weights) begin
            ser_word = bus.wgt_in;
            state_d  = StSendW;
          end else begin
            ser_word = bus.win_in;
            state_d  = StSendX;
          end
        end
      end
      StSendW: begin
        if (ser_last) begin
          // Window was latched at accept; input may have moved on since.
          ser_load = 1'b1;
          ser_word = win_q;
          state_d  = StSendX;
        end else begin
          ser_step = 1'b1;
        end
      end
      StSendX: begin
        if (ser_last) begin
          ser_clear = 1'b1;
          set_cnt_d = '0;
          state_d   = StSettle;
        end else begin
          ser_step = 1'b1;
        end
      end
      StSettle: begin
        if (set_cnt_q == SetW'(SETTLE_CYCLES - 1)) begin
          state_d = StCap0;
        end else begin
          set_cnt_d = set_cnt_q + SetW'(1);
        end
      end
      StCap0:  state_d = StCap1;
      StCap1:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      set_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      err_q     <= 1'b0;
      wsel_q    <= 1'b0;
      rd_q      <= 1'b1;
      f0_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      set_cnt_q <= set_cnt_d;
      busy_q    <= (state_d != StIdle);
      done_q    <= (state_q == StCap1);
      // Link control follows the state it will be in, so byte and strobes line up.
      wsel_q    <= (state_d == StSendW);
      rd_q      <= !is_send_state(state_d);
      if (state_q == StCap0) begin
        f0_q <= bus.link_resp[TOGGLE_BIT];
      end
      if (state_q == StCap1) begin
        result_q <= bus.link_resp[RESULT_W-1:0];
        err_q    <= (bus.link_resp[TOGGLE_BIT] == f0_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      win_q <= bus.win_in;
    end
  end

  conv_link_serializer u_ser (
    .clk   (clk),
    .clear (ser_clear || !rst_n),
    .load  (ser_load),
    .step  (ser_step),
    .word  (ser_word),
    .data  (ser_data),
    .last  (ser_last)
  );

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.err       = err_q;
  assign bus.link_data = ser_data;
  assign bus.link_wsel = wsel_q;
  assign bus.link_rd   = rd_q;

endmodule
